// File: rtl/round_key_store_pkg.sv
// round_key_store_pkg
//   Shared constants and the state type for the round key store.
//   KEY_S  : round key width in bits
//   NR     : number of AES rounds; NR+1 round keys are held
//   IDX_W  : width of round index ports (2**IDX_W > NR)
//   state_t: key-set state (EMPTY / LOADING / READY)
package round_key_store_pkg;

  localparam int KEY_S    = 128;
  localparam int NR       = 10;
  localparam int IDX_W    = 4;
  localparam int NUM_KEYS = NR + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

endpackage

// File: rtl/round_key_store_ram.sv
// round_key_ram
//   Simple dual-port storage for the round key schedule. One write port and
//   one registered read port. A read and a write to the same address in the
//   same cycle return the old contents (read-before-write). Storage is not
//   reset so the array can map onto distributed RAM or block RAM.
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata only updates when re=1
//   raddr  in   read address
//   rdata  out  registered read data (holds when re=0)
module round_key_ram #(
  parameter int DEPTH = 11,
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both accesses sit in one clocked block; the non-blocking write lands
  // after the read samples the array, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/round_key_store.sv
// round_key_store
//   Captures the NR+1 round keys streamed by key expansion and serves them to
//   the cipher round datapath through a 1-cycle-latency random-access read
//   port, with forward or reverse (decrypt) index mapping. Tracks whether a
//   complete key set is held so a partial or stale schedule is never served.
// Ports
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   w_e         in   write strobe from key expansion
//   round_no    in   index of the key being written
//   round_key   in   round key data
//   kexp_done   in   expansion-complete pulse, coincides with final write
//   rd_req      in   read request
//   rd_decrypt  in   1: physical index = NR - rd_idx, 0: = rd_idx
//   rd_idx      in   logical round index requested
//   rd_key      out  read data (0 when the request was illegal)
//   rd_valid    out  pulse one cycle after each rd_req
//   rd_err      out  qualifies rd_valid: request was illegal
//   keys_ready  out  complete key set held
//   load_err    out  sticky: last load ended incomplete
module round_key_store
  import round_key_store_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             w_e,
  input  logic [IDX_W-1:0] round_no,
  input  logic [KEY_S-1:0] round_key,
  input  logic             kexp_done,
  input  logic             rd_req,
  input  logic             rd_decrypt,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_S-1:0] rd_key,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             keys_ready,
  output logic             load_err
);

  localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);

  state_t          state_reg, state_next;
  logic [NR:0]     mask_reg, mask_next;
  logic            load_err_reg, load_err_next;
  logic            keys_ready_reg;
  logic            rd_valid_reg, rd_err_reg;
  logic            rd_zero_reg;
  logic [NR:0]     wr_onehot;
  logic            restart, wr_en;
  logic            rd_legal;
  logic [IDX_W-1:0] rd_phys;
  logic [KEY_S-1:0] ram_rdata;

  // One-hot decode of the write index into the valid mask.
  for (genvar gi = 0; gi <= NR; gi++) begin : g_wr_dec
    assign wr_onehot[gi] = (round_no == IDX_W'(gi));
  end

  // An index-0 write always starts a new load; other writes only land while
  // a load is in progress and the index is in range.
  assign restart = w_e && (round_no == '0);
  assign wr_en   = restart ||
                   (w_e && (state_reg == ST_LOADING) && (round_no <= NR_IDX));

  // Legality uses the logical index before mapping so an out-of-range decrypt
  // index cannot wrap onto a valid entry.
  assign rd_legal = (state_reg == ST_READY) && (rd_idx <= NR_IDX);
  assign rd_phys  = rd_decrypt ? (NR_IDX - rd_idx) : rd_idx;

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    load_err_next = load_err_reg;

    if (restart) begin
      state_next    = ST_LOADING;
      mask_next     = '0;
      mask_next[0]  = 1'b1;
      load_err_next = 1'b0;
    end else if (wr_en) begin
      mask_next = mask_reg | wr_onehot;
    end

    // Completion is judged on the mask including this cycle's write.
    if ((state_reg == ST_LOADING) && kexp_done) begin
      if (&mask_next) begin
        state_next = ST_READY;
      end else begin
        state_next    = ST_EMPTY;
        load_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_EMPTY;
      mask_reg       <= '0;
      load_err_reg   <= 1'b0;
      keys_ready_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_err_reg     <= 1'b0;
      rd_zero_reg    <= 1'b1;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      load_err_reg   <= load_err_next;
      keys_ready_reg <= (state_next == ST_READY);
      rd_valid_reg   <= rd_req;
      rd_err_reg     <= rd_req && !rd_legal;
      // rd_zero_reg remembers whether the most recent read was illegal so
      // rd_key keeps showing 0 (or the last good key) between requests.
      if (rd_req) begin
        rd_zero_reg <= !rd_legal;
      end
    end
  end

  round_key_ram #(
    .DEPTH (NUM_KEYS),
    .WIDTH (KEY_S),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (round_no),
    .wdata (round_key),
    .re    (rd_req && rd_legal),
    .raddr (rd_phys),
    .rdata (ram_rdata)
  );

  assign rd_key     = rd_zero_reg ? '0 : ram_rdata;
  assign rd_valid   = rd_valid_reg;
  assign rd_err     = rd_err_reg;
  assign keys_ready = keys_ready_reg;
  assign load_err   = load_err_reg;

endmodule

// File: tb/tb_round_key_store.sv
module tb_round_key_store;
  import round_key_store_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             w_e;
  logic [IDX_W-1:0] round_no;
  logic [KEY_S-1:0] round_key;
  logic             kexp_done;
  logic             rd_req;
  logic             rd_decrypt;
  logic [IDX_W-1:0] rd_idx;
  logic [KEY_S-1:0] rd_key;
  logic             rd_valid;
  logic             rd_err;
  logic             keys_ready;
  logic             load_err;

  always #5 clk = ~clk;

  round_key_store dut (
    .clk        (clk),
    .reset      (reset),
    .w_e        (w_e),
    .round_no   (round_no),
    .round_key  (round_key),
    .kexp_done  (kexp_done),
    .rd_req     (rd_req),
    .rd_decrypt (rd_decrypt),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .keys_ready (keys_ready),
    .load_err   (load_err)
  );

  typedef struct {
    logic [KEY_S-1:0] key;
    logic             err;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  logic [KEY_S-1:0] cur_keys [NUM_KEYS];
  int               errors = 0;
  int               checks = 0;

  task automatic idle();
    reset      = 1'b0;
    w_e        = 1'b0;
    round_no   = '0;
    round_key  = '0;
    kexp_done  = 1'b0;
    rd_req     = 1'b0;
    rd_decrypt = 1'b0;
    rd_idx     = '0;
  endtask

  // Pure stimulus: streams writes first..last and records them in the model.
  task automatic load_keys(input int first, input int last, input bit done_last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      idle();
      w_e       = 1'b1;
      round_no  = IDX_W'(i);
      round_key = {$urandom, $urandom, $urandom, $urandom};
      kexp_done = done_last && (i == last);
      cur_keys[i] = round_key;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rd_key !== '0 || rd_valid !== 1'b0 || rd_err !== 1'b0 ||
        keys_ready !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: key=%h valid=%b err=%b ready=%b lerr=%b, expected all 0",
               rd_key, rd_valid, rd_err, keys_ready, load_err);
    end
    checks++;
    if (dut.mask_reg !== '0 || dut.state_reg !== ST_EMPTY) begin
      errors++;
      $display("FAIL reset_state: mask=%b state=%0d, expected mask=0 state=EMPTY",
               dut.mask_reg, dut.state_reg);
    end
  endtask

  task automatic test_empty_read();
    exp_t e;
    @(negedge clk);
    idle();
    rd_req = 1'b1;
    rd_idx = 4'd3;
    sb.push_back('{key: '0, err: 1'b1, tag: "empty_read"});
    @(negedge clk);
    idle();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_err !== e.err || rd_key !== e.key) begin
        errors++;
        $display("FAIL %s: valid=%b err=%b key=%h, expected valid=1 err=%b key=%h",
                 e.tag, rd_valid, rd_err, rd_key, e.err, e.key);
      end
    end
  endtask

  task automatic test_full_load();
    load_keys(0, NR - 1, 1'b0);
    checks++;
    if (keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_load: keys_ready=%b, expected 0", keys_ready);
    end
    load_keys(NR, NR, 1'b1);
    checks++;
    if (keys_ready !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL full_load: keys_ready=%b load_err=%b, expected 1 and 0",
               keys_ready, load_err);
    end
  endtask

  // Back-to-back forward reads of every index, then one idle cycle to see
  // rd_valid drop while rd_key holds.
  task automatic test_fwd_reads(input string tag);
    exp_t e;
    for (int i = 0; i <= NUM_KEYS; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== e.err || rd_key !== e.key) begin
          errors++;
          $display("FAIL %s: valid=%b err=%b key=%h, expected valid=1 err=%b key=%h",
                   e.tag, rd_valid, rd_err, rd_key, e.err, e.key);
        end
      end
      idle();
      if (i < NUM_KEYS) begin
        rd_req = 1'b1;
        rd_idx = IDX_W'(i);
        sb.push_back('{key: cur_keys[i], err: 1'b0, tag: $sformatf("%s_idx%0d", tag, i)});
      end
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== cur_keys[NR]) begin
      errors++;
      $display("FAIL %s_hold: valid=%b err=%b key=%h, expected valid=0 err=0 key=%h",
               tag, rd_valid, rd_err, rd_key, cur_keys[NR]);
    end
  endtask

  task automatic test_decrypt_and_illegal();
    int   idx_t [6];
    bit   dec_t [6];
    exp_t e;
    int   phys;
    idx_t = '{0, 10, 3, 11, 15, 7};
    dec_t = '{1, 1, 1, 0, 1, 0};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== e.err || rd_key !== e.key) begin
          errors++;
          $display("FAIL %s: valid=%b err=%b key=%h, expected valid=1 err=%b key=%h",
                   e.tag, rd_valid, rd_err, rd_key, e.err, e.key);
        end
      end
      idle();
      if (i < 6) begin
        rd_req     = 1'b1;
        rd_idx     = IDX_W'(idx_t[i]);
        rd_decrypt = dec_t[i];
        if (idx_t[i] > NR) begin
          sb.push_back('{key: '0, err: 1'b1, tag: $sformatf("illegal_idx%0d_dec%0d", idx_t[i], dec_t[i])});
        end else begin
          phys = dec_t[i] ? NR - idx_t[i] : idx_t[i];
          sb.push_back('{key: cur_keys[phys], err: 1'b0, tag: $sformatf("map_idx%0d_dec%0d", idx_t[i], dec_t[i])});
        end
      end
    end
  endtask

  task automatic test_ignored_writes();
    exp_t e;
    @(negedge clk);
    idle();
    w_e = 1'b1; round_no = 4'd3; round_key = {4{32'hDEAD_BEEF}}; kexp_done = 1'b1;
    @(negedge clk);
    idle();
    w_e = 1'b1; round_no = 4'd12; round_key = {4{32'h0BAD_F00D}};
    @(negedge clk);
    idle();
    checks++;
    if (keys_ready !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL ignored_write_state: keys_ready=%b load_err=%b, expected 1 and 0",
               keys_ready, load_err);
    end
    rd_req = 1'b1;
    rd_idx = 4'd3;
    sb.push_back('{key: cur_keys[3], err: 1'b0, tag: "ignored_write_readback"});
    @(negedge clk);
    idle();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_err !== e.err || rd_key !== e.key) begin
        errors++;
        $display("FAIL %s: valid=%b err=%b key=%h, expected valid=1 err=%b key=%h",
                 e.tag, rd_valid, rd_err, rd_key, e.err, e.key);
      end
    end
  endtask

  task automatic test_restart_collision();
    exp_t e;
    @(negedge clk);
    idle();
    rd_req    = 1'b1;
    rd_idx    = 4'd0;
    w_e       = 1'b1;
    round_no  = 4'd0;
    round_key = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back('{key: cur_keys[0], err: 1'b0, tag: "collision_old_key"});
    cur_keys[0] = round_key;
    @(negedge clk);
    idle();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_err !== e.err || rd_key !== e.key) begin
        errors++;
        $display("FAIL %s: valid=%b err=%b key=%h, expected valid=1 err=%b key=%h",
                 e.tag, rd_valid, rd_err, rd_key, e.err, e.key);
      end
    end
    checks++;
    if (keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL collision_ready_drop: keys_ready=%b, expected 0", keys_ready);
    end
    rd_req = 1'b1;
    rd_idx = 4'd0;
    sb.push_back('{key: '0, err: 1'b1, tag: "read_while_loading"});
    @(negedge clk);
    idle();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_err !== e.err || rd_key !== e.key) begin
        errors++;
        $display("FAIL %s: valid=%b err=%b key=%h, expected valid=1 err=%b key=%h",
                 e.tag, rd_valid, rd_err, rd_key, e.err, e.key);
      end
    end
    load_keys(1, NR, 1'b1);
    checks++;
    if (keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_restart: keys_ready=%b, expected 1", keys_ready);
    end
  endtask

  task automatic test_incomplete_load();
    load_keys(0, NR - 1, 1'b0);
    @(negedge clk);
    idle();
    kexp_done = 1'b1;
    @(negedge clk);
    idle();
    checks++;
    if (load_err !== 1'b1 || keys_ready !== 1'b0 || dut.state_reg !== ST_EMPTY) begin
      errors++;
      $display("FAIL incomplete_load: load_err=%b keys_ready=%b state=%0d, expected 1 0 EMPTY",
               load_err, keys_ready, dut.state_reg);
    end
    load_keys(0, 0, 1'b0);
    checks++;
    if (load_err !== 1'b0 || keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_err_clear: load_err=%b keys_ready=%b, expected 0 0",
               load_err, keys_ready);
    end
    load_keys(1, NR, 1'b1);
    checks++;
    if (keys_ready !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_after_incomplete: keys_ready=%b load_err=%b, expected 1 0",
               keys_ready, load_err);
    end
  endtask

  task automatic test_reset_midload();
    load_keys(0, 5, 1'b0);
    @(negedge clk);
    idle();
    reset  = 1'b1;
    rd_req = 1'b1;
    rd_idx = 4'd2;
    @(negedge clk);
    idle();
    checks++;
    if (rd_key !== '0 || rd_valid !== 1'b0 || rd_err !== 1'b0 ||
        keys_ready !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midload_outputs: key=%h valid=%b err=%b ready=%b lerr=%b, expected all 0",
               rd_key, rd_valid, rd_err, keys_ready, load_err);
    end
    checks++;
    if (dut.mask_reg !== '0 || dut.state_reg !== ST_EMPTY) begin
      errors++;
      $display("FAIL reset_midload_state: mask=%b state=%0d, expected mask=0 state=EMPTY",
               dut.mask_reg, dut.state_reg);
    end
    load_keys(0, NR, 1'b1);
    checks++;
    if (keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_after_reset: keys_ready=%b, expected 1", keys_ready);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_empty_read();
    test_full_load();
    test_fwd_reads("fwd");
    test_decrypt_and_illegal();
    test_ignored_writes();
    test_restart_collision();
    test_fwd_reads("after_restart");
    test_incomplete_load();
    test_fwd_reads("after_incomplete");
    test_reset_midload();
    test_fwd_reads("after_reset");
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
